// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the registered N-channel multiplexer.
package mux_seq_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_sel_ctrl.sv
// Select register for mux_seq_n: range-checked loads, auto-scan with wrap, sticky error.
module mux_sel_ctrl
  import mux_seq_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_sel_in,
  input  logic             i_sel_load,
  input  logic             i_capture,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_sel_err
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_next;
  logic             r_sel_err;
  logic             w_sel_err_next;
  logic             w_in_range;

  assign w_in_range = (32'(i_sel_in) < CHANNELS);

  // A load always beats the scan step; an out-of-range load leaves the select untouched.
  always_comb begin
    w_sel_next     = r_sel;
    w_sel_err_next = r_sel_err;
    if (i_sel_load) begin
      if (w_in_range) begin
        w_sel_next = i_sel_in;
      end else begin
        w_sel_err_next = 1'b1;
      end
    end else if ((i_mode == MODE_SCAN) && i_capture) begin
      w_sel_next = (r_sel == LastSel) ? '0 : r_sel + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel     <= w_sel_next;
      r_sel_err <= w_sel_err_next;
    end
  end

  assign o_sel     = r_sel;
  assign o_sel_err = r_sel_err;

endmodule

// File: rtl/mux_seq_n.sv
// Registered CHANNELS:1 multiplexer with a one-entry valid/ready output buffer.
module mux_seq_n
  import mux_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  buf_state_e       r_state;
  buf_state_e       w_state_next;
  logic [WIDTH-1:0] r_dout;
  logic [SEL_W-1:0] r_ch;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_err;
  logic             w_capture;
  logic             w_accept;

  assign in_ready  = (r_state == EMPTY) || out_ready;
  assign w_capture = in_valid && in_ready;
  assign w_accept  = (r_state == FULL) && out_ready;

  mux_sel_ctrl #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_sel_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mode     (mode),
    .i_sel_in   (sel_in),
    .i_sel_load (sel_load),
    .i_capture  (w_capture),
    .o_sel      (w_sel),
    .o_sel_err  (w_sel_err)
  );

  // Compare against each legal code so unused select codes (non power-of-two) route zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_sel == SEL_W'(k)) begin
        w_sel_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_capture) w_state_next = FULL;
      end
      FULL: begin
        if (w_accept && !w_capture) w_state_next = EMPTY;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_dout  <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_dout <= w_sel_data;
        r_ch   <= w_sel;
      end
    end
  end

  assign dout      = r_dout;
  assign ch_out    = r_ch;
  assign out_valid = (r_state == FULL);
  assign sel_err   = w_sel_err;

endmodule

// File: tb/tb_mux_seq_n.sv
// Bench for mux_seq_n: a 4-channel and a 3-channel instance share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_mux_seq_n;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        in_valid;
  logic        mode;
  logic [1:0]  sel_in;
  logic        sel_load;
  logic        out_ready;

  logic [3:0]  dout4, dout3;
  logic [1:0]  ch4, ch3;
  logic        ov4, ov3, ir4, ir3, err4, err3;

  int n_err = 0;
  int n_chk = 0;

  mux_seq_n #(.WIDTH(4), .CHANNELS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir4),
    .mode(mode), .sel_in(sel_in), .sel_load(sel_load), .dout(dout4), .ch_out(ch4),
    .out_valid(ov4), .out_ready(out_ready), .sel_err(err4)
  );

  mux_seq_n #(.WIDTH(4), .CHANNELS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din[11:0]), .in_valid(in_valid), .in_ready(ir3),
    .mode(mode), .sel_in(sel_in), .sel_load(sel_load), .dout(dout3), .ch_out(ch3),
    .out_valid(ov3), .out_ready(out_ready), .sel_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model; index 0 = 4-channel instance, 1 = 3-channel instance.
  int unsigned nch [2] = '{4, 3};
  logic [3:0]  m_dout  [2];
  logic [1:0]  m_ch    [2];
  logic [1:0]  m_sel   [2];
  logic        m_valid [2];
  logic        m_err   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_dout[i]  <= '0;
        m_ch[i]    <= '0;
        m_sel[i]   <= '0;
        m_valid[i] <= 1'b0;
        m_err[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic cap;
        logic [1:0] nsel;
        cap = in_valid && (!m_valid[i] || out_ready);
        if (cap) begin
          m_dout[i]  <= 4'((din >> (4 * m_sel[i])) & 16'hF);
          m_ch[i]    <= m_sel[i];
          m_valid[i] <= 1'b1;
        end else if (out_ready) begin
          m_valid[i] <= 1'b0;
        end
        nsel = m_sel[i];
        if (sel_load) begin
          if (int'(sel_in) < int'(nch[i])) nsel = sel_in;
          else m_err[i] <= 1'b1;
        end else if (mode && cap) begin
          nsel = 2'((int'(m_sel[i]) + 1) % int'(nch[i]));
        end
        m_sel[i] <= nsel;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("u4 dout",      32'(dout4), 32'(m_dout[0]));
      chk("u4 ch_out",    32'(ch4),   32'(m_ch[0]));
      chk("u4 out_valid", 32'(ov4),   32'(m_valid[0]));
      chk("u4 in_ready",  32'(ir4),   32'(!m_valid[0] || out_ready));
      chk("u4 sel_err",   32'(err4),  32'(m_err[0]));
      chk("u3 dout",      32'(dout3), 32'(m_dout[1]));
      chk("u3 ch_out",    32'(ch3),   32'(m_ch[1]));
      chk("u3 out_valid", 32'(ov3),   32'(m_valid[1]));
      chk("u3 in_ready",  32'(ir3),   32'(!m_valid[1] || out_ready));
      chk("u3 sel_err",   32'(err3),  32'(m_err[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1; din = '0; in_valid = 1'b0; mode = 1'b0;
    sel_in = '0; sel_load = 1'b0; out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(ov4), 0);
    chk("rst dout", 32'(dout4), 0);
    chk("rst in_ready", 32'(ir4), 1);
    chk("rst sel_err", 32'(err4), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Manual load of channel 2, then capture.
    sel_load = 1'b1; sel_in = 2'd2;
    tick();
    sel_load = 1'b0; in_valid = 1'b1; din = 16'hDCBA;
    tick();
    chk("manual u4 dout", 32'(dout4), 32'hC);
    chk("manual u4 ch_out", 32'(ch4), 2);
    chk("manual u4 out_valid", 32'(ov4), 1);
    chk("manual u3 dout", 32'(dout3), 32'hC);

    // Scan from channel 0 with continuous flow.
    in_valid = 1'b0; sel_load = 1'b1; sel_in = 2'd0; mode = 1'b1;
    tick();
    sel_load = 1'b0; in_valid = 1'b1; din = 16'h4321;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("scan u4 ch_out", 32'(ch4), 32'(k % 4));
      chk("scan u4 dout", 32'(dout4), 32'(k % 4 + 1));
    end

    // Stall for three cycles holding ch1, then release.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall u4 dout", 32'(dout4), 2);
      chk("stall u4 ch_out", 32'(ch4), 1);
      chk("stall u4 in_ready", 32'(ir4), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("release u4 ch_out", 32'(ch4), 2);

    // Load 1 while the scan capture at select 3 happens.
    sel_load = 1'b1; sel_in = 2'd1;
    tick();
    chk("load+scan u4 ch_out", 32'(ch4), 3);
    chk("load+scan u4 dout", 32'(dout4), 4);
    sel_load = 1'b0;
    tick();
    chk("after load u4 ch_out", 32'(ch4), 1);

    // Out-of-range load on the 3-channel instance.
    mode = 1'b0; in_valid = 1'b0; sel_load = 1'b1; sel_in = 2'd1;
    tick();
    sel_in = 2'd3;
    tick();
    chk("badsel u3 sel_err", 32'(err3), 1);
    chk("badsel u4 sel_err", 32'(err4), 0);
    sel_load = 1'b0; in_valid = 1'b1; din = 16'h4321;
    tick();
    chk("badsel u3 ch_out held", 32'(ch3), 1);
    chk("badsel u4 ch_out", 32'(ch4), 3);
    in_valid = 1'b0; sel_load = 1'b1; sel_in = 2'd0;
    tick();
    chk("sticky u3 sel_err", 32'(err3), 1);
    sel_load = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      din       = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel_load  = ($urandom_range(0, 7) == 0);
      sel_in    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      tick();
    end

    // Reset while the buffer holds data.
    sel_load = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("pre-reset u4 out_valid", 32'(ov4), 1);
    rst_n = 1'b0;
    #1;
    chk("async u4 out_valid", 32'(ov4), 0);
    chk("async u4 dout", 32'(dout4), 0);
    chk("async u4 ch_out", 32'(ch4), 0);
    chk("async u3 out_valid", 32'(ov3), 0);
    chk("async u3 sel_err", 32'(err3), 0);
    chk("async u4 in_ready", 32'(ir4), 1);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      din       = 16'($urandom);
      in_valid  = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel_load  = ($urandom_range(0, 5) == 0);
      sel_in    = 2'($urandom_range(0, 3));
      mode      = ($urandom_range(0, 1) != 0);
      tick();
    end

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
